// File: rtl/mem_responder.sv
// Word-organised RAM responder for the core's load/store and fetch port.
// One request at a time, programmable wait states, RV32I sub-word access.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_shift;
    logic          w_oor;
    logic          w_ok;
    logic          w_misal;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load;
    logic          w_err;
    logic          w_commit;

    assign w_idx   = r_addr[AW+1:2];
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {r_addr[1:0], 3'b000};
    // Bits above the RAM index must be zero: no wrap-around.
    assign w_oor   = |r_addr[31:AW+2];

    always_comb begin
        w_ok    = 1'b0;
        w_misal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = 32'd0;
        w_load  = 32'd0;
        unique case (r_funct3)
            3'b000: begin
                w_ok    = 1'b1;
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
                w_load  = {{24{w_shift[7]}}, w_shift[7:0]};
            end
            3'b001: begin
                w_ok    = 1'b1;
                w_misal = r_addr[0];
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
                w_load  = {{16{w_shift[15]}}, w_shift[15:0]};
            end
            3'b010: begin
                w_ok    = 1'b1;
                w_misal = |r_addr[1:0];
                w_be    = 4'b1111;
                w_wdata = r_wdata;
                w_load  = w_shift;
            end
            3'b100: begin
                w_ok   = !r_we;
                w_load = {24'd0, w_shift[7:0]};
            end
            3'b101: begin
                w_ok    = !r_we;
                w_misal = r_addr[0];
                w_load  = {16'd0, w_shift[15:0]};
            end
            default: ;
        endcase
    end

    assign w_err    = !w_ok || w_misal || w_oor;
    assign w_commit = (r_state == S_ACCESS) && r_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_funct3    <= 3'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_funct3    <= req_funct3;
                        r_cnt       <= 4'(WAIT_CYCLES);
                        r_req_ready <= 1'b0;
                        r_state     <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= w_err;
                    r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, corner sequences and random
// traffic against a byte-level memory model, on WAIT_CYCLES=1 and 0 builds.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        rready;
    int          cur;

    logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_ready;
    logic [31:0] d_rsp_rdata;
    logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_err, z_rsp_ready;
    logic [31:0] z_rsp_rdata;

    assign d_req_valid = valid && (cur == 0);
    assign z_req_valid = valid && (cur == 1);
    assign d_rsp_ready = rready && (cur == 0);
    assign z_rsp_ready = rready && (cur == 1);

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;
    assign m_req_ready = (cur == 1) ? z_req_ready : d_req_ready;
    assign m_rsp_valid = (cur == 1) ? z_rsp_valid : d_rsp_valid;
    assign m_rsp_err   = (cur == 1) ? z_rsp_err   : d_rsp_err;
    assign m_rsp_rdata = (cur == 1) ? z_rsp_rdata : d_rsp_rdata;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(d_req_valid), .req_ready(d_req_ready),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_funct3(f3),
        .rsp_valid(d_rsp_valid), .rsp_rdata(d_rsp_rdata),
        .rsp_err(d_rsp_err), .rsp_ready(d_rsp_ready)
    );

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_funct3(f3),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err), .rsp_ready(z_rsp_ready)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mw [1024];
    logic [31:0] mz [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: byte-level behaviour from access size, lane and range.
    task automatic model(input logic mwe, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] fn, output logic e, output logic [31:0] rd);
        int nb;
        int lane;
        int depth;
        logic [31:0] idx;
        logic [31:0] w;
        logic [31:0] mask;
        case (fn)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2:       nb = 4;
            default:    nb = 0;
        endcase
        if (mwe && fn[2]) nb = 0;
        depth = (cur == 1) ? 64 : 1024;
        lane  = int'(a[1:0]);
        idx   = a >> 2;
        rd    = 32'd0;
        e     = 1'b0;
        if (nb == 0) e = 1'b1;
        else if ((lane % nb) != 0) e = 1'b1;
        else if (idx >= 32'(depth)) e = 1'b1;
        if (!e) begin
            w = (cur == 1) ? mz[idx] : mw[idx];
            if (mwe) begin
                for (int k = 0; k < nb; k++) w[8*(lane+k) +: 8] = wd[8*k +: 8];
                if (cur == 1) mz[idx] = w;
                else mw[idx] = w;
            end else begin
                rd = w >> (8 * lane);
                if (nb < 4) begin
                    mask = (32'd1 << (8 * nb)) - 32'd1;
                    rd = rd & mask;
                    if (!fn[2] && rd[8*nb-1]) rd = rd | ~mask;
                end
            end
        end
    endtask

    task automatic do_req(input logic twe, input logic [31:0] ta, input logic [31:0] twd,
                          input logic [2:0] tf, output logic [31:0] ord,
                          output logic oerr, output int lat);
        @(negedge clk);
        we = twe; addr = ta; wdata = twd; f3 = tf; valid = 1'b1;
        chk("req_ready_idle", 32'(m_req_ready), 32'd1);
        @(posedge clk);
        #1 valid = 1'b0;
        lat = 0;
        while (!m_rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("rsp_valid_arrives", 32'(m_rsp_valid), 32'd1);
        ord  = m_rsp_rdata;
        oerr = m_rsp_err;
        @(negedge clk);
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
        chk("rsp_valid_clear", 32'(m_rsp_valid), 32'd0);
        chk("req_ready_back", 32'(m_req_ready), 32'd1);
    endtask

    // Runs one request; expectation from the table when use_tbl, else the model.
    task automatic run(input string nm, input logic twe, input logic [31:0] ta,
                       input logic [31:0] twd, input logic [2:0] tf,
                       input logic use_tbl, input logic te, input logic [31:0] trd);
        logic        me;
        logic [31:0] mrd;
        logic [31:0] ard;
        logic        ae;
        int          lat;
        model(twe, ta, twd, tf, me, mrd);
        if (use_tbl) begin
            me  = te;
            mrd = trd;
        end
        do_req(twe, ta, twd, tf, ard, ae, lat);
        chk({nm, "_err"}, 32'(ae), 32'(me));
        chk({nm, "_rdata"}, ard, mrd);
        chk({nm, "_lat"}, 32'(lat), (cur == 1) ? 32'd1 : 32'd2);
    endtask

    typedef struct {
        string       nm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic        me;
        logic [31:0] mrd;
        logic [31:0] ra;
        logic [31:0] held;
        logic        rwe;
        logic [2:0]  rf;
        int          lat;

        tbl.push_back('{"sw10",      1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 1'b0, 32'h0});
        tbl.push_back('{"lw10",      1'b0, 32'h10,   32'h0,        3'b010, 1'b0, 32'hDEADBEEF});
        tbl.push_back('{"sw20",      1'b1, 32'h20,   32'h11223344, 3'b010, 1'b0, 32'h0});
        tbl.push_back('{"sb21",      1'b1, 32'h21,   32'h000000F0, 3'b000, 1'b0, 32'h0});
        tbl.push_back('{"lw20_a",    1'b0, 32'h20,   32'h0,        3'b010, 1'b0, 32'h1122F044});
        tbl.push_back('{"lb21",      1'b0, 32'h21,   32'h0,        3'b000, 1'b0, 32'hFFFFFFF0});
        tbl.push_back('{"lbu21",     1'b0, 32'h21,   32'h0,        3'b100, 1'b0, 32'h000000F0});
        tbl.push_back('{"sh22",      1'b1, 32'h22,   32'h00008001, 3'b001, 1'b0, 32'h0});
        tbl.push_back('{"lh22",      1'b0, 32'h22,   32'h0,        3'b001, 1'b0, 32'hFFFF8001});
        tbl.push_back('{"lhu22",     1'b0, 32'h22,   32'h0,        3'b101, 1'b0, 32'h00008001});
        tbl.push_back('{"lw20_b",    1'b0, 32'h20,   32'h0,        3'b010, 1'b0, 32'h8001F044});
        tbl.push_back('{"lw13_mis",  1'b0, 32'h13,   32'h0,        3'b010, 1'b1, 32'h0});
        tbl.push_back('{"sh21_mis",  1'b1, 32'h21,   32'h0000BEEF, 3'b001, 1'b1, 32'h0});
        tbl.push_back('{"lw20_c",    1'b0, 32'h20,   32'h0,        3'b010, 1'b0, 32'h8001F044});
        tbl.push_back('{"lw_oor",    1'b0, 32'h1000, 32'h0,        3'b010, 1'b1, 32'h0});
        tbl.push_back('{"ld_f3_011", 1'b0, 32'h10,   32'h0,        3'b011, 1'b1, 32'h0});
        tbl.push_back('{"st_f3_100", 1'b1, 32'h10,   32'h0,        3'b100, 1'b1, 32'h0});
        tbl.push_back('{"lw10_b",    1'b0, 32'h10,   32'h0,        3'b010, 1'b0, 32'hDEADBEEF});
        tbl.push_back('{"lb13",      1'b0, 32'h13,   32'h0,        3'b000, 1'b0, 32'hFFFFFFDE});
        tbl.push_back('{"lhu12",     1'b0, 32'h12,   32'h0,        3'b101, 1'b0, 32'h0000DEAD});

        cur = 0; rst = 1'b0; valid = 1'b0; rready = 1'b0;
        we = 1'b0; addr = 32'd0; wdata = 32'd0; f3 = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 32'(m_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", m_rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(m_rsp_err), 32'd0);
        repeat (5) @(negedge clk);
        chk("idle_no_rsp", 32'(m_rsp_valid), 32'd0);

        for (int i = 0; i < 16; i++)
            run("init", 1'b1, 32'(i * 4), $urandom, 3'b010, 1'b0, 1'b0, 32'd0);

        foreach (tbl[i])
            run(tbl[i].nm, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3,
                1'b1, tbl[i].err, tbl[i].rdata);

        // Backpressure: response held while a stray request is ignored.
        model(1'b0, 32'h10, 32'd0, 3'b010, me, mrd);
        @(negedge clk);
        we = 1'b0; addr = 32'h10; f3 = 3'b010; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        lat = 0;
        while (!m_rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("bp_valid", 32'(m_rsp_valid), 32'd1);
        held = m_rsp_rdata;
        chk("bp_rdata", held, mrd);
        @(negedge clk);
        we = 1'b1; addr = 32'h10; wdata = 32'd0; f3 = 3'b010; valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(m_rsp_valid), 32'd1);
            chk("bp_hold_rdata", m_rsp_rdata, held);
            chk("bp_req_ready", 32'(m_req_ready), 32'd0);
        end
        @(negedge clk);
        valid = 1'b0; rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
        chk("bp_release_idle", 32'(m_req_ready), 32'd1);
        chk("bp_release_valid", 32'(m_rsp_valid), 32'd0);
        run("bp_after", 1'b0, 32'h10, 32'd0, 3'b010, 1'b0, 1'b0, 32'd0);

        // Reset during WAIT of a store must abort the write.
        @(negedge clk);
        we = 1'b1; addr = 32'h30; wdata = 32'hA5A5A5A5; f3 = 3'b010; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(m_req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run("abort_lw30", 1'b0, 32'h30, 32'd0, 3'b010, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 150; i++) begin
            rwe = 1'($urandom_range(0, 1));
            rf  = 3'($urandom_range(0, 7));
            ra  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) ra = 32'h1000 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) ra = $urandom;
            run("rnd", rwe, ra, $urandom, rf, 1'b0, 1'b0, 32'd0);
        end

        cur = 1;
        for (int i = 0; i < 16; i++)
            run("z_init", 1'b1, 32'(i * 4), $urandom, 3'b010, 1'b0, 1'b0, 32'd0);
        run("z_sw8", 1'b1, 32'h8, 32'h12345678, 3'b010, 1'b1, 1'b0, 32'h0);
        run("z_lw8", 1'b0, 32'h8, 32'h0, 3'b010, 1'b1, 1'b0, 32'h12345678);
        run("z_oor", 1'b0, 32'h100, 32'h0, 3'b010, 1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 60; i++) begin
            rwe = 1'($urandom_range(0, 1));
            rf  = 3'($urandom_range(0, 7));
            ra  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) ra = 32'h100 + 32'($urandom_range(0, 63));
            run("z_rnd", rwe, ra, $urandom, rf, 1'b0, 1'b0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
